// File: rtl/pipe5_ex_divider_if.sv
// Handshake/bus bundle between the EX stage and the iterative divider.
//   master : EX stage / hazard unit side (drives operands, start, flush)
//   slave  : divider side (drives busy, div_active, done, result)
// Signals:
//   start      EX holds a divide/remainder instruction (level)
//   is_signed  1 = DIV/REM, 0 = DIVU/REMU
//   rem_sel    1 = remainder, 0 = quotient
//   dividend   rs1 value
//   divisor    rs2 value
//   flush      abort the current operation
//   busy       stall request (combinational)
//   div_active divider is not idle
//   done       one-cycle result-valid pulse
//   result     quotient or remainder, valid while done=1
interface pipe5_ex_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic             rem_sel;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             flush;
  logic             busy;
  logic             div_active;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, is_signed, rem_sel, dividend, divisor, flush,
    input  busy, div_active, done, result
  );

  modport slave (
    input  start, is_signed, rem_sel, dividend, divisor, flush,
    output busy, div_active, done, result
  );
endinterface

// File: rtl/pipe5_ex_divider.sv
// Iterative RV32M divide unit (DIV/DIVU/REM/REMU) for the EX stage.
// Radix-2 restoring division, one quotient bit per cycle, with a
// single-cycle path for divide-by-zero and signed overflow.
// Ports:
//   CLK   clock
//   nRST  asynchronous active-low reset
//   bus   pipe5_ex_divider_if.slave (operands, start/flush, busy/done/result)
module pipe5_ex_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  pipe5_ex_divider_if.slave   bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    count_q, count_d;
  logic             is_signed_q, is_signed_d;
  logic             rem_sel_q, rem_sel_d;
  logic             sign_q_q, sign_q_d;
  logic             sign_r_q, sign_r_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;

  // Operand conditioning in IDLE: signs, magnitudes and special cases
  logic             a_neg, b_neg, div_zero, ovf;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    a_neg    = bus.is_signed & bus.dividend[WIDTH-1];
    b_neg    = bus.is_signed & bus.divisor[WIDTH-1];
    // |MIN_NEG| wraps back to MIN_NEG, read as an unsigned magnitude
    a_mag    = a_neg ? -bus.dividend : bus.dividend;
    b_mag    = b_neg ? -bus.divisor  : bus.divisor;
    div_zero = (bus.divisor == '0);
    ovf      = bus.is_signed && (bus.dividend == MIN_NEG) && (bus.divisor == '1);
  end

  // One restoring step: the shifted remainder needs WIDTH+1 bits
  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] quo_step, rem_step, q_fix, r_fix;

  always_comb begin
    rem_sh   = {rem_q, quo_q[WIDTH-1]};
    trial    = rem_sh - {1'b0, dvs_q};
    quo_step = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    rem_step = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    q_fix    = (is_signed_q && sign_q_q) ? -quo_step : quo_step;
    r_fix    = (is_signed_q && sign_r_q) ? -rem_step : rem_step;
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    count_d     = count_q;
    is_signed_d = is_signed_q;
    rem_sel_d   = rem_sel_q;
    sign_q_d    = sign_q_q;
    sign_r_d    = sign_r_q;
    done_d      = 1'b0;
    result_d    = result_q;

    case (state_q)
      S_IDLE: begin
        if (!bus.flush && bus.start) begin
          is_signed_d = bus.is_signed;
          rem_sel_d   = bus.rem_sel;
          sign_q_d    = a_neg ^ b_neg;
          sign_r_d    = a_neg;
          dvs_d       = b_mag;
          count_d     = '0;
          if (div_zero) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            quo_d    = '1;
            rem_d    = bus.dividend;
            result_d = bus.rem_sel ? bus.dividend : '1;
          end else if (ovf) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            quo_d    = MIN_NEG;
            rem_d    = '0;
            result_d = bus.rem_sel ? '0 : MIN_NEG;
          end else begin
            state_d = S_CALC;
            rem_d   = '0;
            quo_d   = a_mag;
          end
        end
      end
      S_CALC: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          quo_d   = quo_step;
          rem_d   = rem_step;
          count_d = count_q + CW'(1);
          if (count_q == CW'(WIDTH-1)) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = rem_sel_q ? r_fix : q_fix;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= S_IDLE;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      count_q     <= '0;
      is_signed_q <= 1'b0;
      rem_sel_q   <= 1'b0;
      sign_q_q    <= 1'b0;
      sign_r_q    <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      count_q     <= count_d;
      is_signed_q <= is_signed_d;
      rem_sel_q   <= rem_sel_d;
      sign_q_q    <= sign_q_d;
      sign_r_q    <= sign_r_d;
      done_q      <= done_d;
      result_q    <= result_d;
    end
  end

  // busy must stall the same cycle the instruction shows up, so it is
  // decoded from inputs; nRST gating keeps it low while reset is held.
  // A flush landing on the DONE cycle suppresses the pulse.
  assign bus.busy       = nRST & (((state_q == S_IDLE) & bus.start & ~bus.flush) |
                                  (state_q == S_CALC));
  assign bus.div_active = (state_q != S_IDLE);
  assign bus.done       = done_q & ~bus.flush;
  assign bus.result     = result_q;

endmodule

// File: tb/tb_pipe5_ex_divider.sv
// Self-checking bench for pipe5_ex_divider: directed vectors, randomized
// operations against a plain-arithmetic reference model, flush, reset and
// back-to-back scenarios.
module tb_pipe5_ex_divider;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  pipe5_ex_divider_if #(.WIDTH(32)) bus ();

  pipe5_ex_divider #(.WIDTH(32)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic        sg;
    logic        rs;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t dv [0:13] = '{
    '{1'b0, 1'b0, 32'd100,        32'd7,          32'd14,         33},
    '{1'b0, 1'b1, 32'd100,        32'd7,          32'd2,          33},
    '{1'b1, 1'b0, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   33},
    '{1'b1, 1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   33},
    '{1'b1, 1'b0, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   33},
    '{1'b1, 1'b1, 32'd7,          32'hFFFFFFFE,   32'd1,          33},
    '{1'b0, 1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   1},
    '{1'b0, 1'b1, 32'd5,          32'd0,          32'd5,          1},
    '{1'b1, 1'b0, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   1},
    '{1'b1, 1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   1},
    '{1'b1, 1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1},
    '{1'b1, 1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h00000000,   1},
    '{1'b0, 1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h00000000,   33},
    '{1'b0, 1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   33}
  };

  // Reference model: RISC-V M-extension semantics in plain arithmetic
  function automatic logic [31:0] ref_div(input logic sg, input logic rs,
                                          input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return rs ? a : 32'hFFFFFFFF;
    if (sg) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return rs ? 32'h0 : 32'h80000000;
      return rs ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    end
    return rs ? (a % b) : (a / b);
  endfunction

  function automatic int ref_lat(input logic sg, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (sg && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  // Wait for the next cycle boundary and settle just after it
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Runs one op from the current cycle (cycle 0); returns observations only.
  // busy_bad counts cycles where busy was not 1 before done, or 1 at done.
  task automatic run_op(input logic sg, input logic rs, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res,
                        output int lat, output int busy_bad);
    bus.start     = 1'b1;
    bus.is_signed = sg;
    bus.rem_sel   = rs;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.flush     = 1'b0;
    lat = -1;
    busy_bad = 0;
    res = 32'hDEADBEEF;
    for (int c = 0; c < 40 && lat < 0; c++) begin
      @(negedge CLK);
      if (bus.done) begin
        lat = c;
        res = bus.result;
        if (bus.busy) busy_bad++;
      end else if (!bus.busy) begin
        busy_bad++;
      end
      next_cycle();
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    tests_run++;
    if ({bus.busy, bus.div_active, bus.done} !== 3'b000 || bus.result !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: busy/active/done=%b result=%h expected 000 / 00000000",
               {bus.busy, bus.div_active, bus.done}, bus.result);
    end
    next_cycle();
    nRST = 1'b1;
    next_cycle();
  endtask

  task automatic test_directed();
    logic [31:0] res;
    int lat, bb;
    for (int i = 0; i < 14; i++) begin
      run_op(dv[i].sg, dv[i].rs, dv[i].a, dv[i].b, res, lat, bb);
      tests_run++;
      if (res !== dv[i].exp) begin
        tests_failed++;
        $display("FAIL directed_result[%0d]: got %h expected %h", i, res, dv[i].exp);
      end
      tests_run++;
      if (lat !== dv[i].lat) begin
        tests_failed++;
        $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, dv[i].lat);
      end
      tests_run++;
      if (bb !== 0) begin
        tests_failed++;
        $display("FAIL directed_busy[%0d]: bad busy cycles %0d expected 0", i, bb);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, res;
    logic sg, rs;
    int lat, bb, mode;
    for (int i = 0; i < 40; i++) begin
      a    = $urandom;
      b    = $urandom;
      sg   = 1'($urandom_range(0, 1));
      rs   = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 7);
      case (mode)
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 100));
        default: ;
      endcase
      run_op(sg, rs, a, b, res, lat, bb);
      tests_run++;
      if (res !== ref_div(sg, rs, a, b) || lat !== ref_lat(sg, a, b) || bb !== 0) begin
        tests_failed++;
        $display("FAIL random[%0d] sg=%b rs=%b a=%h b=%h: got %h lat %0d busybad %0d expected %h lat %0d",
                 i, sg, rs, a, b, res, lat, bb, ref_div(sg, rs, a, b), ref_lat(sg, a, b));
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int lat, bb, early_done;
    early_done = 0;
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.rem_sel = 1'b0;
    bus.dividend = 32'd100; bus.divisor = 32'd7; bus.flush = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (bus.done) early_done++;
      next_cycle();
    end
    bus.flush = 1'b1;
    @(negedge CLK);
    tests_run++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_calc_cycle: busy=%b done=%b expected busy=1 done=0", bus.busy, bus.done);
    end
    next_cycle();
    bus.flush = 1'b0; bus.start = 1'b0;
    @(negedge CLK);
    tests_run++;
    if (bus.div_active !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || early_done !== 0) begin
      tests_failed++;
      $display("FAIL flush_idle_after: active=%b busy=%b done=%b early_done=%0d expected 0 0 0 0",
               bus.div_active, bus.busy, bus.done, early_done);
    end
    next_cycle();
    run_op(1'b0, 1'b0, 32'd9, 32'd3, res, lat, bb);
    tests_run++;
    if (res !== 32'd3 || lat !== 33 || bb !== 0) begin
      tests_failed++;
      $display("FAIL flush_restart: got %h lat %0d busybad %0d expected 00000003 lat 33 busybad 0",
               res, lat, bb);
    end
    // flush and start together in IDLE: flush wins
    bus.start = 1'b1; bus.flush = 1'b1; bus.dividend = 32'd8; bus.divisor = 32'd2;
    @(negedge CLK);
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_idle_priority_busy: got %b expected 0", bus.busy);
    end
    next_cycle();
    bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge CLK);
    tests_run++;
    if (bus.div_active !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_idle_priority_state: active=%b expected 0", bus.div_active);
    end
    next_cycle();
    // flush on the DONE cycle of a divide-by-zero suppresses the pulse
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.rem_sel = 1'b1;
    bus.dividend = 32'd77; bus.divisor = 32'd0;
    next_cycle();
    bus.flush = 1'b1;
    @(negedge CLK);
    tests_run++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_done_cycle: done=%b busy=%b expected 0 0", bus.done, bus.busy);
    end
    next_cycle();
    bus.flush = 1'b0; bus.start = 1'b0;
    @(negedge CLK);
    tests_run++;
    if (bus.div_active !== 1'b0 || bus.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_done_after: active=%b done=%b expected 0 0", bus.div_active, bus.done);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    int early_done;
    early_done = 0;
    bus.start = 1'b1; bus.is_signed = 1'b1; bus.rem_sel = 1'b0;
    bus.dividend = 32'h12345678; bus.divisor = 32'd3; bus.flush = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      if (bus.done) early_done++;
      next_cycle();
    end
    nRST = 1'b0;
    #1;
    tests_run++;
    if ({bus.busy, bus.div_active, bus.done} !== 3'b000 || bus.result !== 32'h0 || early_done !== 0) begin
      tests_failed++;
      $display("FAIL reset_mid_op: busy/active/done=%b result=%h early_done=%0d expected 000 00000000 0",
               {bus.busy, bus.div_active, bus.done}, bus.result, early_done);
    end
    next_cycle();
    bus.start = 1'b0;
    nRST = 1'b1;
    @(negedge CLK);
    tests_run++;
    if (bus.div_active !== 1'b0 || bus.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_release: active=%b done=%b expected 0 0", bus.div_active, bus.done);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2;
    int l1, l2, b1, b2;
    run_op(1'b0, 1'b0, 32'd1, 32'd1, r1, l1, b1);
    run_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, r2, l2, b2);
    tests_run++;
    if (r1 !== 32'd1 || l1 !== 33 || b1 !== 0) begin
      tests_failed++;
      $display("FAIL b2b_first: got %h lat %0d busybad %0d expected 00000001 lat 33 busybad 0", r1, l1, b1);
    end
    tests_run++;
    if (r2 !== 32'hFFFFFFFF || l2 !== 33 || b2 !== 0) begin
      tests_failed++;
      $display("FAIL b2b_second: got %h lat %0d busybad %0d expected ffffffff lat 33 busybad 0", r2, l2, b2);
    end
  endtask

  initial begin
    nRST = 1'b0;
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.rem_sel = 1'b0;
    bus.dividend = 32'h0; bus.divisor = 32'h0; bus.flush = 1'b0;
    #1;
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
